// File: rtl/spi_cfg_arbiter.sv
// Round-robin arbiter sharing one SPI bus among several configuration requesters.
// Each grant shifts a 32-bit word LSB-first, optionally followed by a 32-bit read-back phase.
module spi_cfg_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned N_DEV   = 2,
  parameter int unsigned DEV_W   = 1,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 600
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_rd,
  input  logic [N_REQ*DEV_W-1:0] req_dev,
  input  logic [N_REQ*32-1:0]    req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [31:0]            rdata,
  output logic                   busy,
  output logic                   spi_clk,
  output logic                   spi_mosi,
  input  logic                   spi_miso,
  output logic [N_DEV-1:0]       spi_le
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SHIFT,
    WR_GAP,
    RD_SHIFT,
    RD_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [31:0]        data_q, data_d;
  logic [DEV_W-1:0]   dev_q, dev_d;
  logic               rd_q, rd_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [4:0]         bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [31:0]        shreg_q, shreg_d;

  logic [N_REQ-1:0]   gnt_d, ack_d;
  logic [31:0]        rdata_d;
  logic               sclk_d, mosi_d;
  logic [N_DEV-1:0]   le_d;

  logic [31:0]        data_arr [N_REQ];
  logic [DEV_W-1:0]   dev_arr  [N_REQ];

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  int unsigned        idx;

  // Active-low enable for the addressed device; out-of-range selects leave all lines high.
  function automatic logic [N_DEV-1:0] le_for(input logic [DEV_W-1:0] dev);
    logic [N_DEV-1:0] le;
    le = '1;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (32'(dev) == i) le[i] = 1'b0;
    end
    return le;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[i*32 +: 32];
      dev_arr[i]  = req_dev[i*DEV_W +: DEV_W];
    end
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PTR_W'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    dev_d   = dev_q;
    rd_d    = rd_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    gnt_d   = gnt;
    ack_d   = '0;
    rdata_d = rdata;
    sclk_d  = spi_clk;
    mosi_d  = spi_mosi;
    le_d    = spi_le;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d        = WR_SHIFT;
          ptr_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          data_d         = data_arr[win_idx];
          dev_d          = dev_arr[win_idx];
          rd_d           = req_rd[win_idx];
          le_d           = le_for(dev_arr[win_idx]);
          mosi_d         = data_arr[win_idx][0];
          sclk_d         = 1'b0;
          div_d          = '0;
          bit_d          = '0;
        end
      end

      WR_SHIFT, RD_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_RISE) begin
          sclk_d = 1'b1;
          if (state_q == RD_SHIFT) shreg_d = {spi_miso, shreg_q[31:1]};
        end
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 5'd31) begin
            mosi_d  = 1'b0;
            le_d    = '1;
            gap_d   = '0;
            state_d = (state_q == WR_SHIFT) ? WR_GAP : RD_GAP;
          end else begin
            bit_d = bit_q + 5'd1;
            // The word is shifted down so the next bit always sits at data_q[1].
            if (state_q == WR_SHIFT) begin
              mosi_d = data_q[1];
              data_d = {1'b0, data_q[31:1]};
            end
          end
        end
      end

      WR_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          if (rd_q) begin
            state_d = RD_SHIFT;
            le_d    = le_for(dev_q);
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
          end else begin
            state_d       = IDLE;
            ack_d[ptr_q]  = 1'b1;
            gnt_d         = '0;
          end
        end
      end

      RD_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          state_d      = IDLE;
          rdata_d      = shreg_q;
          ack_d[ptr_q] = 1'b1;
          gnt_d        = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(N_REQ - 1);
      data_q   <= '0;
      dev_q    <= '0;
      rd_q     <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      shreg_q  <= '0;
      gnt      <= '0;
      ack      <= '0;
      rdata    <= '0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_le   <= '1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      dev_q    <= dev_d;
      rd_q     <= rd_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shreg_q  <= shreg_d;
      gnt      <= gnt_d;
      ack      <= ack_d;
      rdata    <= rdata_d;
      spi_clk  <= sclk_d;
      spi_mosi <= mosi_d;
      spi_le   <= le_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/spi_cfg_arbiter.md
Name: spi_cfg_arbiter

Overview:
- Shares one physical SPI bus (SCLK, MOSI, MISO) among N_REQ configuration requesters: clock-chip init, ADC init and host register access.
- Each requester submits one 32-bit word, LSB-first, targeted at one of N_DEV devices, each with its own active-low latch-enable.
- Optional read-back: a second 32-bit phase captures MISO.
- Sits between the board bring-up sequencers / host register file and the board SPI pins. It replaces per-sequencer private SPI drivers.

Parameters:
- N_REQ, 3, number of requesters; requester 0 has first priority after reset.
- N_DEV, 2, number of SPI slave devices (one LE line each).
- DEV_W, 1, width of each device-select field; N_DEV <= 2^DEV_W.
- CLK_DIV, 4, SCLK half-period in clk cycles; minimum 2.
- GAP_CYC, 600, minimum clk cycles LE is held high after each 32-bit phase.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req  in  N_REQ  per-requester transaction request, level, held until ack
- req_rd  in  N_REQ  1 = write phase followed by a read phase
- req_dev  in  N_REQ*DEV_W  target device per requester (slice i = requester i)
- req_data  in  N_REQ*32  word to shift per requester (slice i = requester i)
- gnt  out  N_REQ  one-hot, high for the whole transaction of the granted requester
- ack  out  N_REQ  one-cycle completion pulse to the granted requester
- rdata  out  32  read-phase capture; valid in the ack cycle, held until the next read completes
- busy  out  1  high whenever state is not IDLE
- spi_clk  out  1  SCLK, idle low
- spi_mosi  out  1  MOSI, idle 0
- spi_miso  in  1  MISO
- spi_le  out  N_DEV  per-device latch enable, active-low, idle all-ones

Behaviour:
- Reset (rst_n low at a clk edge), effective at that edge including mid-transaction:
  - outputs: gnt=0, ack=0, rdata=0, busy=0, spi_clk=0, spi_mosi=0, spi_le=all 1.
  - state=IDLE; round-robin pointer=N_REQ-1.
  - An aborted transaction gets no ack.
- States: IDLE, WR_SHIFT, WR_GAP, RD_SHIFT, RD_GAP.
- IDLE:
  - If any req bit is high, grant the first set bit searching from pointer+1 modulo N_REQ.
  - Same edge: set gnt, set pointer to the winner, latch req_data / req_dev / req_rd of the winner, go to WR_SHIFT.
  - Simultaneous requests are resolved by round-robin only.
- WR_SHIFT:
  - First cycle: spi_le[dev]=0, spi_mosi=bit0, spi_clk=0.
  - Each bit lasts 2*CLK_DIV cycles: spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI changes only while spi_clk is low (at bit boundaries).
  - After 32 bits (64*CLK_DIV cycles): spi_clk=0, spi_le[dev]=1, spi_mosi=0, go to WR_GAP.
- WR_GAP:
  - Count GAP_CYC cycles with LE high.
  - Then go to RD_SHIFT if req_rd was latched; otherwise pulse ack[winner], drop gnt, go to IDLE (same edge).
- RD_SHIFT:
  - Same SCLK/LE timing as WR_SHIFT, with spi_mosi held 0.
  - On each clk edge where spi_clk goes 0 to 1, shift in: shreg <= {spi_miso, shreg[31:1]}. The first received bit ends in bit0.
  - After 32 bits: LE high, go to RD_GAP.
- RD_GAP:
  - Count GAP_CYC cycles.
  - Then load rdata with shreg, pulse ack, drop gnt, return to IDLE.
- Latency:
  - Write-only: req seen in IDLE at edge 0 -> LE low from edge 1 -> ack high in cycle 1+64*CLK_DIV+GAP_CYC.
  - Read adds 64*CLK_DIV+GAP_CYC.
  - The next grant comes no earlier than the cycle after ack (IDLE lasts at least one cycle).
- Request handling:
  - A req dropped before grant is never served.
  - A req dropped after grant is ignored: the transaction completes and ack still pulses.
  - Input changes during a transaction have no effect (inputs are latched at grant).
- Only spi_le[latched dev] ever goes low; all other LE lines stay high.
- req_dev >= N_DEV: transaction runs with all LE lines high (no device latched), ack still pulses.

Test Plan:
- Reset then req[0] with data 32'hEB400320, dev 0, rd=0 (CLK_DIV=4, GAP_CYC=8):
  - MOSI bits observed at SCLK rising edges, LSB first, equal 0x20, 0x03, 0x40, 0xEB.
  - spi_le=2'b10 for exactly 256 cycles; ack[0] at cycle 1+256+8; spi_le[1] never low.
- req[0], req[1], req[2] asserted in the same cycle and held:
  - grants in order 0, 1, 2.
  - Re-asserting req[0] during requester 2's transaction: 0 is granted next; no requester is starved.
- Read: req[1] with rd=1, dev 1, data 32'h0000001E; bench drives MISO with 32'h12345678 LSB-first on SCLK rising edges:
  - rdata=32'h12345678 in the ack cycle.
  - Two LE-low windows of 64*CLK_DIV cycles, separated by a GAP_CYC-cycle high window.
- rst_n low for one cycle mid-WR_SHIFT (bit 10):
  - next cycle: spi_le all 1, spi_clk=0, gnt=0, busy=0; no ack.
  - A fresh req[2] afterwards is served from bit0.
- req[1] dropped before grant while req[2] is high:
  - only 2 is granted.
- req[2] dropped 5 cycles after grant:
  - transaction completes and ack[2] still pulses.
- Back-to-back writes from requester 0 (req held high):
  - exactly one IDLE cycle between ack and the next LE falling edge.
